// File: rtl/mult_seq_pkg.sv
// Shared constants and state encoding for the sequential multiplier.
// Optional feature: MULT_SIGNED_EN selects the two's-complement build.
package mult_seq_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_ABS_A  = 3'd1;
    localparam state_t S_ABS_B  = 3'd2;
    localparam state_t S_CALC   = 3'd3;
    localparam state_t S_NEG_LO = 3'd4;
    localparam state_t S_NEG_HI = 3'd5;
    localparam state_t S_DONE   = 3'd6;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

endpackage

// File: rtl/adder.sv
// 32-bit ripple-carry adder shared between the ALU and the multiplier sequencer.
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cy_in,
    output logic [31:0] sum,
    output logic        carryflag,
    output logic        overflowflag
);

    always_comb begin
        logic c;
        logic c_msb;
        c     = cy_in;
        c_msb = 1'b0;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            if (i == 31) c_msb = c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        carryflag    = c;
        overflowflag = c_msb ^ c;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add 32x32 multiplier that time-multiplexes one shared ripple adder.
// Define MULT_SIGNED_EN for the two's-complement build (adds ABS/NEG states).
module mult_seq_ctrl
    import mult_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_cin;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cy;

`ifdef MULT_SIGNED_EN
    logic               neg;
    logic               neg_cy;
`endif

    adder u_adder (
        .a            (add_a),
        .b            (add_b),
        .cy_in        (add_cin),
        .sum          (add_sum),
        .carryflag    (add_cy),
        .overflowflag ()
    );

    // Conditional negation is done as (x ^ mask) + carry-in so it reuses the adder.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_CALC: begin
                add_a = acc_hi;
                add_b = acc_lo[0] ? mcand : '0;
            end
`ifdef MULT_SIGNED_EN
            S_ABS_A: begin
                add_a   = mcand ^ {WIDTH{mcand[WIDTH-1]}};
                add_cin = mcand[WIDTH-1];
            end
            S_ABS_B: begin
                add_a   = acc_lo ^ {WIDTH{acc_lo[WIDTH-1]}};
                add_cin = acc_lo[WIDTH-1];
            end
            S_NEG_LO: begin
                add_a   = acc_lo ^ {WIDTH{neg}};
                add_cin = neg;
            end
            S_NEG_HI: begin
                add_a   = acc_hi ^ {WIDTH{neg}};
                add_cin = neg_cy;
            end
`endif
            default: ;
        endcase
    end

    // product is loaded on the edge that enters DONE so it is valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
`ifdef MULT_SIGNED_EN
            neg     <= 1'b0;
            neg_cy  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_lo <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
`ifdef MULT_SIGNED_EN
                        neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        state  <= S_ABS_A;
`else
                        state  <= S_CALC;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                S_ABS_A: begin
                    mcand <= add_sum;
                    state <= S_ABS_B;
                end
                S_ABS_B: begin
                    acc_lo <= add_sum;
                    state  <= S_CALC;
                end
                S_NEG_LO: begin
                    acc_lo <= add_sum;
                    neg_cy <= add_cy;
                    state  <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    acc_hi  <= add_sum;
                    product <= {add_sum, acc_lo};
                    state   <= S_DONE;
                end
`endif
                S_CALC: begin
                    {acc_hi, acc_lo} <= {add_cy, add_sum, acc_lo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
`ifdef MULT_SIGNED_EN
                        state <= S_NEG_LO;
`else
                        product <= {add_cy, add_sum, acc_lo[WIDTH-1:1]};
                        state   <= S_DONE;
`endif
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl; signed vectors run when MULT_SIGNED_EN is defined.
module tb_mult_seq_ctrl;

`ifdef MULT_SIGNED_EN
    localparam int LAT = 37;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int checks = 0;
    int errors = 0;

    mult_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle after DONE.
    task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [63:0] exp, input logic [63:0] prev,
                                 input int poke_calc, input bit poke_done);
        int cyc;
        int busy_cnt;
        bit seen;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (cyc == 5) checkOutput({tag, " held"}, product, prev);
            if (done) seen = 1'b1;
            else if (poke_calc != 0 && cyc == poke_calc) begin
                start = 1'b1;
                a = 32'h1;
                b = 32'h1;
            end else start = 1'b0;
        end
        checkOutput({tag, " product"}, product, exp);
        checkOutput({tag, " latency"}, 64'(cyc), 64'(LAT));
        checkOutput({tag, " busy cycles"}, 64'(busy_cnt), 64'(LAT - 1));
        if (poke_done) begin
            start = 1'b1;
            a = 32'h2;
            b = 32'h2;
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, " done pulse"}, {63'd0, done}, 64'd0);
        checkOutput({tag, " idle busy"}, {63'd0, busy}, 64'd0);
        if (poke_done) begin
            repeat (3) @(negedge clk);
            checkOutput({tag, " no queued start"}, {63'd0, busy}, 64'd0);
            checkOutput({tag, " product kept"}, product, exp);
        end
    endtask

    initial begin
        #1;
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset product", product, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 64'd0, 0, 1'b0);
`ifdef MULT_SIGNED_EN
        applyStimulus("-2x3", 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 64'hF, 0, 1'b0);
        applyStimulus("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFA, 0, 1'b0);
        applyStimulus("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 64'd1, 0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("hold idle", product, 64'h4000_0000_0000_0000);
        applyStimulus("0xdeadbeef", 32'd0, 32'hDEAD_BEEF, 64'd0, 64'h4000_0000_0000_0000, 0, 1'b0);
`else
        applyStimulus("maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 64'hF, 0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("hold idle", product, 64'hFFFF_FFFE_0000_0001);
        applyStimulus("0xdeadbeef", 32'd0, 32'hDEAD_BEEF, 64'd0, 64'hFFFF_FFFE_0000_0001, 0, 1'b0);
`endif
        applyStimulus("9x9 ignore", 32'd9, 32'd9, 64'd81, 64'd0, 10, 1'b1);
        applyStimulus("4x4", 32'd4, 32'd4, 64'd16, 64'd81, 0, 1'b0);

        a = 32'd100;
        b = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("pre-reset busy", {63'd0, busy}, 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("abort busy", {63'd0, busy}, 64'd0);
        checkOutput("abort done", {63'd0, done}, 64'd0);
        checkOutput("abort product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("7x6", 32'd7, 32'd6, 64'd42, 64'd0, 0, 1'b0);

        applyStimulus("b2b first", 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 64'd42, 0, 1'b0);
        applyStimulus("b2b second", 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001,
                      64'h0000_0001_2345_6780, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Multi-cycle 32x32 multiplier sequencer that owns one instance of the 32-bit ripple `adder` and time-multiplexes it to produce a 64-bit product by shift-and-add. It sits beside the ALU and gives the CPU a multiply capability without a second array adder. A start/busy/done handshake hands operands in and the product back.

## Interface
- `WIDTH`, 32, operand width; only 32 is supported because the shared `adder` is fixed at 32 bits.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  32  multiplicand; captured on an accepted start.
- `b`  in  32  multiplier; captured on an accepted start.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  one-cycle pulse; the product is valid at that cycle.
- `product`  out  64  registered result; held until the next accepted start.

## Operation
- Registers:
  - `mcand[31:0]`
  - `acc_hi[31:0]`
  - `acc_lo[31:0]`, which holds the multiplier and shifts right
  - `cnt[4:0]`
  - `neg`, the result sign (signed build only)
- States: IDLE, ABS_A, ABS_B, CALC, NEG_LO, NEG_HI, DONE. ABS_x and NEG_x exist only with `MULT_SIGNED_EN`.
- IDLE:
  - On `start=1`: load `mcand=a`, `acc_lo=b`, `acc_hi=0`, `cnt=0`.
  - Go to CALC (unsigned build) or ABS_A (signed build).
  - `product` is not cleared.
- CALC (adder a=`acc_hi`, b=`acc_lo[0] ? mcand : 0`, cy_in=0):
  - `{acc_hi, acc_lo} <= {carryflag, sum, acc_lo[31:1]}`
  - `cnt <= cnt+1`
  - Leave after the 32nd iteration (`cnt==31`) for NEG_LO (signed build) or DONE.
- DONE:
  - `product <= {acc_hi, acc_lo}`; with `MULT_SIGNED_EN` this is the post-negate value.
  - `done=1` for this cycle only; next state is IDLE.
- `start` is ignored in every state except IDLE, including DONE; no queuing.
- The adder's `overflowflag` is unused. `carryflag` is consumed only in CALC and NEG_LO.
- The adder is driven only by this block; in IDLE/DONE its inputs are 0.

## Timing
- Reset (async, immediate): state=IDLE, `busy=0`, `done=0`, `product=0`, all internal registers 0. Reset mid-operation aborts with no partial result.
- Unsigned latency: start accepted at edge E, CALC on edges E+1..E+32, `done` high during the cycle after edge E+32 → 33 cycles start-to-done.
- Signed latency: fixed 37 cycles (+2 ABS, +2 NEG), independent of operand signs.
- `busy` rises the cycle after acceptance and falls when DONE is entered.
- Back-to-back: the earliest next start is accepted at the edge that leaves DONE→IDLE plus one, i.e. start high in IDLE.

## Configuration
- `MULT_SIGNED_EN` defined: operands are two's complement, and every step below is computed through the shared adder.
  - ABS_A: `mcand <= (a ^ {32{a[31]}}) + a[31]`.
  - ABS_B: the same conditional negate applied to `acc_lo`.
  - `neg = a[31]^b[31]`.
  - NEG_LO: low word `(acc_lo ^ {32{neg}}) + neg`; its carry is latched.
  - NEG_HI: high word `(acc_hi ^ {32{neg}}) + latched carry`.
  - 0x80000000 yields magnitude 0x80000000 (correct as unsigned).
- `MULT_SIGNED_EN` undefined: unsigned only; ABS/NEG states and `neg` are not built.

## Structure
- Package `mult_seq_pkg`: state enum, `WIDTH=32`, `ITER=32`, `CNT_W=5`.
- One sub-module: the existing `adder` (ports `a`, `b`, `cy_in`, `sum`, `carryflag`, `overflowflag`), instantiated once.
- The FSM and the adder input muxes live in `mult_seq_ctrl`.

## Test plan
- Unsigned 3 × 5: `product=0x000000000000000F`, `done` exactly 33 cycles after start, `busy` high 32 cycles.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → `0xFFFFFFFE00000001`. 0 × 0xDEADBEEF → 0. `product` holds until the next start.
- Start pulsed during CALC and during DONE: ignored. Result unchanged; a subsequent start in IDLE runs normally.
- `rst` asserted at CALC iteration 10: outputs zero immediately, state IDLE. A new 7×6 then returns 42.
- Signed build: −2 × 3 → `0xFFFFFFFFFFFFFFFA`. −1 × −1 → 1. 0x80000000 × 0x80000000 → `0x4000000000000000`. Each done at 37 cycles.
- Two back-to-back multiplies (start re-asserted first IDLE cycle): both products correct; `done` pulses once each.
